// File: rtl/uart_pkg.sv
// UART transmitter shared definitions: register map, STATUS bits, FSM states.
package uart_pkg;

   localparam logic [1:0] REG_TXDATA   = 2'd0;
   localparam logic [1:0] REG_STATUS   = 2'd1;
   localparam logic [1:0] REG_BAUD_DIV = 2'd2;

   localparam int ST_FULL     = 0;
   localparam int ST_EMPTY    = 1;
   localparam int ST_BUSY     = 2;
   localparam int ST_OVERFLOW = 3;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational read port; pointers carry one extra
// wrap bit so full and empty are distinguishable.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_comb begin
      wptr_d = push ? wptr_q + PTR_ONE : wptr_q;
      rptr_d = pop ? rptr_q + PTR_ONE : rptr_q;
   end

   assign empty    = (wptr_q == rptr_q);
   assign full     = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign pop_data = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wptr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, transmit FIFO and
// bit-timing state machine driving a registered serial line.
module uart_tx
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH       = 8,
   parameter int DIV_WIDTH        = 16,
   parameter int DEFAULT_BAUD_DIV = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read_enable,
   input  logic        write_enable,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        tx
);

   localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

   uart_tx_state_t       state_q, state_d;
   logic [DIV_WIDTH-1:0] baud_q, baud_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] eff_div;
   logic [2:0]           idx_q, idx_d;
   logic [7:0]           shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 ovf_q, ovf_d;

   logic       push, pop, full, empty, bit_end;
   logic [7:0] fifo_dout;
   logic       wr_txdata, wr_status, wr_baud;
   logic       unused_ok;

   assign unused_ok = ^{address, write_data};

   sync_fifo #(
      .WIDTH(8),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push),
      .pop      (pop),
      .push_data(write_data[7:0]),
      .pop_data (fifo_dout),
      .full     (full),
      .empty    (empty)
   );

   always_comb begin
      wr_txdata = write_enable && (address[3:2] == REG_TXDATA);
      wr_status = write_enable && (address[3:2] == REG_STATUS);
      wr_baud   = write_enable && (address[3:2] == REG_BAUD_DIV);
      // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
      push      = wr_txdata && (!full || pop);
      ovf_d     = ovf_q;
      if (wr_txdata && !push) begin
         ovf_d = 1'b1;
      end
      if (wr_status && write_data[ST_OVERFLOW]) begin
         ovf_d = 1'b0;
      end
      baud_d = wr_baud ? write_data[DIV_WIDTH-1:0] : baud_q;
   end

   always_comb begin
      read_data = '0;
      if (read_enable) begin
         unique case (address[3:2])
            REG_STATUS: begin
               read_data[ST_FULL]     = full;
               read_data[ST_EMPTY]    = empty;
               read_data[ST_BUSY]     = (state_q != IDLE);
               read_data[ST_OVERFLOW] = ovf_q;
            end
            REG_BAUD_DIV: read_data[DIV_WIDTH-1:0] = baud_q;
            default: read_data = '0;
         endcase
      end
   end

   always_comb begin
      eff_div = (baud_q == '0) ? ONE : baud_q;
      bit_end = (cnt_q == div_q - ONE);
      state_d = state_q;
      cnt_d   = cnt_q + ONE;
      div_d   = div_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = fifo_dout;
               div_d   = eff_div;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               div_d   = eff_div;
               idx_d   = 3'd0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               div_d = eff_div;
               if (idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
                  tx_d  = shift_q[idx_q + 3'd1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               div_d = eff_div;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_dout;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            cnt_d   = '0;
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= DIV_WIDTH'(DEFAULT_BAUD_DIV);
         div_q   <= DIV_WIDTH'(DEFAULT_BAUD_DIV);
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_d;
      end
   end

   assign tx = tx_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Memory-mapped serial transmitter peripheral on the core's data bus, in the same responder slot style as the gpio and virtual console peripherals.
- Core writes bytes into a transmit FIFO; a bit-timing state machine serialises them onto a single 8N1 line (LSB first, idle high).
- Provides status and baud-divisor registers so software can poll and pace output.
- Hardware counterpart to the simulation-only console output path.

Parameters:
- FIFO_DEPTH, 8, transmit FIFO entries; power of two, at least 2.
- DIV_WIDTH, 16, width of the baud divisor register.
- DEFAULT_BAUD_DIV, 16, divisor value loaded at reset (clock cycles per bit).

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous reset, active high.
- address  input  32  data-bus address; only bits [3:2] are decoded (word offset).
- read_enable  input  1  peripheral selected for read (from the DMA controller decode).
- write_enable  input  1  peripheral selected for write.
- write_data  input  32  write data from the core.
- read_data  output  32  register read data; combinational.
- tx  output  1  serial line, registered.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Registers, by address[3:2]:
  - 0 TXDATA: a write pushes write_data[7:0]; reads return 0.
  - 1 STATUS: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), other bits 0. Writing 1 to bit3 clears overflow; all other write bits are ignored.
  - 2 BAUD_DIV: read/write, low DIV_WIDTH bits, upper bits read 0.
  - 3: reserved; reads 0, writes ignored.
- read_data is valid combinationally whenever read_enable is high and is 0 otherwise. Reads have no side effects.
- Writes take effect at the rising edge where write_enable is high.
- FIFO push:
  - A write to TXDATA while the FIFO is full (after accounting for a same-cycle pop) is dropped and sets overflow.
  - Simultaneous push and pop when full: pop frees a slot, the push is accepted, and overflow is not set.
- Reset values: tx=1, FIFO empty, overflow=0, BAUD_DIV=DEFAULT_BAUD_DIV, FSM=IDLE, counters 0.
- Effective divisor: a BAUD_DIV value of 0 is treated as 1.
  - The divisor is latched at the start of each bit period; a mid-bit write applies from the next bit period.
- Each bit holds tx constant for exactly the latched divisor number of cycles.
- FSM states, with tx driven from registered state:
  - IDLE: tx=1. If the FIFO is not empty, pop into the shift register and go to START.
  - START: tx=0 for one bit period, then go to DATA with bit index 0.
  - DATA: tx=shift[index]. After each bit period, increment the index; after index 7 go to STOP.
  - STOP: tx=1 for one bit period. Then pop the next byte and go to START if the FIFO is non-empty (back-to-back, no idle gap); otherwise go to IDLE.
- Latency: a write to an empty FIFO in IDLE is accepted at edge E. The FSM pops at edge E+1, and tx is low in the cycle after E+1.
- Frame length: exactly 10×div cycles from the first start-bit cycle to the end of the stop bit.
- Reset mid-frame: tx returns to 1 on the next edge, the frame is abandoned and the FIFO is flushed.
- Counters wrap only within their defined ranges. The FIFO pointers are log2(FIFO_DEPTH)+1 bits so full and empty can be distinguished.

Decomposition:
- uart_pkg holds:
  - register offset constants (TXDATA=0, STATUS=1, BAUD_DIV=2);
  - STATUS bit-position constants;
  - the uart_tx_state_t enum {IDLE, START, DATA, STOP}.
- One sub-module: sync_fifo, parameterised by WIDTH and DEPTH, providing push, pop, full, empty and data out. It uses the same clock and reset and is reusable for a later receiver.

Test Plan:
- Reset, then read STATUS → 0x2 (empty), BAUD_DIV reads 16, tx=1 throughout.
- BAUD_DIV=4, write TXDATA 0x55 → tx low 1 cycle after acceptance + 1, then the pattern 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop) with each bit 4 cycles, busy=1 during the frame, then IDLE with tx=1.
- BAUD_DIV=2, write 0xA3 then 0x0F on consecutive cycles → two frames of 20 cycles each with no idle gap; STATUS returns to 0x2 after the second stop bit.
- BAUD_DIV=100, write 9 bytes quickly:
  - first byte popped, next 8 fill the FIFO → full=1;
  - a 10th write is dropped → overflow=1;
  - write STATUS=0x8 → overflow=0;
  - only bytes 1–9 appear on tx.
- BAUD_DIV=0 → each bit lasts 1 cycle (10-cycle frame). Change BAUD_DIV from 3 to 5 mid-data-bit → the current bit stays 3 cycles and later bits are 5 cycles.
- Assert reset mid-DATA of 0xFF with 3 bytes queued → next cycle tx=1, STATUS=0x2, BAUD_DIV=16, no further frames.
